// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD digit-entry block.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam int unsigned BCD_MAX = 9;

    // Bits needed to hold any value below 10**digits.
    function automatic int unsigned bin_width(input int unsigned digits);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return 32'($clog2(p));
    endfunction

endpackage

// File: rtl/bcd_entry_manager_input_debouncer.sv
// Synchronizes and debounces a bouncy push-button level and emits a
// one-cycle pulse when the debounced level rises.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic accept
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Level toggles on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            accept <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            accept <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level  <= sync2;
                    cnt    <= '0;
                    accept <= sync2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_entry_manager.sv
// Collects a DIGITS-long decimal operand one BCD digit per button press and
// presents it both as packed BCD and as binary.
module bcd_entry_manager
    import bcd_entry_pkg::*;
#(
    parameter  int unsigned DIGITS          = 3,
    parameter  int unsigned DEBOUNCE_CYCLES = 4,
    localparam int unsigned NUM_W           = 4 * DIGITS,
    localparam int unsigned BIN_W           = bin_width(DIGITS),
    localparam int unsigned CNT_W           = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       dip_switch,
    input  logic             input_ready,
    input  logic             clear,
    output logic [NUM_W-1:0] number_out,
    output logic [BIN_W-1:0] number_bin,
    output logic [CNT_W-1:0] digit_count,
    output logic             ready,
    output logic             error
);

    logic [3:0] dip_sync1;
    logic [3:0] dip_sync2;
    logic       accept;

    state_t           state;
    state_t           state_nxt;
    logic [NUM_W-1:0] number_nxt;
    logic [BIN_W-1:0] bin_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             ready_nxt;
    logic             error_nxt;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strobe (
        .clk   (clk),
        .reset (reset),
        .raw   (input_ready),
        .accept(accept)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dip_sync1 <= 4'd0;
            dip_sync2 <= 4'd0;
        end else begin
            dip_sync1 <= dip_switch;
            dip_sync2 <= dip_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            number_out  <= '0;
            number_bin  <= '0;
            digit_count <= '0;
            ready       <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            number_out  <= number_nxt;
            number_bin  <= bin_nxt;
            digit_count <= count_nxt;
            ready       <= ready_nxt;
            error       <= error_nxt;
        end
    end

    // Clear beats accept; an invalid digit only raises error.
    always_comb begin
        state_nxt  = state;
        number_nxt = number_out;
        bin_nxt    = number_bin;
        count_nxt  = digit_count;
        ready_nxt  = ready;
        error_nxt  = 1'b0;

        if (clear) begin
            state_nxt  = IDLE;
            number_nxt = '0;
            bin_nxt    = '0;
            count_nxt  = '0;
            ready_nxt  = 1'b0;
        end else if (accept) begin
            if (dip_sync2 > 4'(BCD_MAX)) begin
                error_nxt = 1'b1;
            end else begin
                case (state)
                    IDLE, COLLECT: begin
                        number_nxt = (number_out << 4) | NUM_W'(dip_sync2);
                        bin_nxt    = (number_bin << 3) + (number_bin << 1) + BIN_W'(dip_sync2);
                        count_nxt  = digit_count + CNT_W'(1);
                        if (digit_count == CNT_W'(DIGITS - 1)) begin
                            state_nxt = FULL;
                            ready_nxt = 1'b1;
                        end else begin
                            state_nxt = COLLECT;
                        end
                    end
                    FULL: begin
                        number_nxt = NUM_W'(dip_sync2);
                        bin_nxt    = BIN_W'(dip_sync2);
                        count_nxt  = CNT_W'(1);
                        state_nxt  = (DIGITS == 1) ? FULL : COLLECT;
                        ready_nxt  = (DIGITS == 1);
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/bcd_entry_manager.md
Name: bcd_entry_manager

Overview:
Parametrised successor to the single-operand DIP-switch digit reader. It collects a DIGITS-long decimal number one BCD digit at a time from a 4-bit DIP switch and a debounced push-button strobe. It outputs the packed BCD value and its binary equivalent to the downstream adder datapath. It also validates digits, supports clear, and restarts automatically once the number is complete.

Parameters:
DIGITS, 3, number of decimal digits per operand (1..8)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a strobe level change is accepted (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
dip_switch  in  4  BCD digit value; asynchronous, must be stable while input_ready is asserted
input_ready  in  1  raw push-button strobe; asynchronous and bouncy
clear  in  1  synchronous, active-high; discards the current entry
number_out  out  4*DIGITS  packed BCD; most recently entered digit in the low nibble
number_bin  out  BIN_W  binary value of number_out; BIN_W = clog2(10**DIGITS)
digit_count  out  clog2(DIGITS+1)  digits accepted in the current number
ready  out  1  level; high while DIGITS valid digits are held
error  out  1  one-cycle pulse on an invalid digit (>9)

Behaviour:
- Reset (reset=0, async): number_out=0, number_bin=0, digit_count=0, ready=0, error=0. Synchronizers, debounce counter and debounced level all clear to 0. FSM goes to IDLE. Reset mid-entry aborts the entry immediately.
- input_ready and dip_switch each pass through a 2-flop synchronizer.
- Debounce: the counter increments while the synchronized strobe differs from the debounced level and resets to 0 when they match. When it reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Accept: a one-cycle pulse on the rising edge of the debounced level. A held button yields exactly one accept. Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Latency: for a clean input_ready rise, accept occurs on edge 2+DEBOUNCE_CYCLES. Outputs reflect the digit after edge 3+DEBOUNCE_CYCLES.
- The digit is the synchronized dip_switch value in the accept cycle.
- FSM states:
  - IDLE (count=0): on a valid accept, go to COLLECT, or directly to FULL if DIGITS=1.
  - COLLECT (0<count<DIGITS): on a valid accept, count++. Go to FULL when count reaches DIGITS.
  - FULL (count=DIGITS, ready=1): on a valid accept, restart. number_out={0..,digit}, number_bin=digit, count=1, ready=0, state COLLECT (or FULL if DIGITS=1).
- Valid accept outside restart:
  - number_out = (number_out<<4) | digit.
  - number_bin = (number_bin<<3) + (number_bin<<1) + digit, computed at BIN_W width. It cannot overflow, since the maximum is 10**DIGITS-1.
- Invalid accept (digit>9): error=1 for one cycle. No other state changes, in any FSM state.
- clear=1: all data outputs and count go to 0, ready=0, state IDLE. Clear has priority over a simultaneous accept, which is discarded with no error pulse. The debouncer is not cleared.
- ready is a registered level. It rises in the same cycle number_out/number_bin show the final digit.

Decomposition:
- Package bcd_entry_pkg:
  - state_t enum {IDLE, COLLECT, FULL}
  - BCD_MAX=9 constant
  - function bin_width(digits) returning clog2(10**digits)
- Sub-module input_debouncer, parameter DEBOUNCE_CYCLES. Contains the 2-flop sync, stability counter and rising-edge accept pulse. It is instantiated once for input_ready.
- Instantiate a separate 2-flop sync for dip_switch in the top.

Test Plan:
(DIGITS=3, DEBOUNCE_CYCLES=4, 10-unit clock)
1. Reset held low 3 cycles, then released -> all outputs 0, state IDLE. Asserting reset low mid-entry after digits 4,5 -> outputs 0 asynchronously, before the next edge.
2. Enter 3,2,1, each strobe high 10 cycles and low 10 cycles -> number_out=12'h321, number_bin=321, digit_count=3, ready=1. Each update lands exactly 7 edges after the strobe rise.
3. Glitch: input_ready high 2 cycles, and a bounce pattern 1-0-1 with 2-cycle segments -> no accept, outputs unchanged. A bouncy press that settles high -> exactly one accept.
4. dip_switch=4'hC strobed in COLLECT with count=1 -> error high exactly one cycle, number_out, number_bin and count unchanged.
5. After 9,9,9 -> number_bin=999, ready=1. Then strobe 7 -> number_out=12'h007, number_bin=7, count=1, ready=0.
6. clear asserted in the accept cycle of the 2nd digit -> all outputs 0, no error pulse, state IDLE. The next digit 5 -> number_out=12'h005, count=1.
